uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter among NUM_PORTS AXI-Stream requesters.
//   Round-robin arbitration with packet lock: a grant is held until the granted port's tlast beat is accepted, or MAX_BURST beats have passed.
//   Sits between the requesters (command, status, debug ports) and the uart s_axis_* input.
// PARAMETERS
//   NUM_PORTS   4      number of requesters, 2..16
//   DATA_WIDTH  8      beat width; matches the uart DATA_WIDTH
//   MAX_BURST   0      beats per grant before forced release; 0 = unlimited (tlast only)
//   HDR_BASE    8'hF0  header byte base; used only with UART_ARB_HDR_EN
// PORTS
//   clk            in   1                     system clock
//   rst            in   1                     synchronous, active-high reset
//   s_axis_tdata   in   NUM_PORTS*DATA_WIDTH  requester data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid  in   NUM_PORTS             per-port valid
//   s_axis_tlast   in   NUM_PORTS             per-port end of packet
//   s_axis_tready  out  NUM_PORTS             per-port ready
//   m_axis_tdata   out  DATA_WIDTH            to uart s_axis_tdata
//   m_axis_tvalid  out  1                     to uart s_axis_tvalid
//   m_axis_tready  in   1                     from uart s_axis_tready
//   grant_id       out  $clog2(NUM_PORTS)     currently or last granted port
//   busy           out  1                     high while a grant is held
// BEHAVIOUR
//   - Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, grant_id=0, busy=0, state=IDLE, rr_ptr=NUM_PORTS-1 (port 0 has first priority), beat_cnt=0.
//   - FSM states: IDLE, HDR (macro only), XFER.
//   - IDLE, any s_axis_tvalid set:
//       winner = first valid port searching rr_ptr+1, rr_ptr+2, ... (mod NUM_PORTS);
//       register grant_id=winner, busy=1, beat_cnt=0;
//       next state XFER (or HDR with the macro).
//     No request: stay in IDLE.
//   - XFER is a combinational pass-through of the granted port g:
//       m_axis_tdata = s_axis_tdata[g], m_axis_tvalid = s_axis_tvalid[g], s_axis_tready[g] = m_axis_tready;
//       all other s_axis_tready are 0.
//   - A beat is accepted when m_axis_tvalid && m_axis_tready; each accepted beat increments beat_cnt.
//   - Release on the accepted beat that either has s_axis_tlast[g]=1 or, with MAX_BURST!=0, is beat MAX_BURST.
//     On release: rr_ptr=g, busy=0, next state IDLE.
//   - Latency: 1 idle cycle (arbitration bubble) between grant decision and first beat, and again after each release.
//     Data path adds no register; zero-cycle data latency.
//   - Granted port drops tvalid mid-packet: the grant is held, m_axis_tvalid=0, and no other port is served until tlast or MAX_BURST.
//   - A requester asserting tvalid while another port holds the grant waits; there is no preemption.
//   - Single requester: it is re-granted after each 1-cycle IDLE bubble.
//   - rr_ptr wraps from NUM_PORTS-1 to 0.
//   - beat_cnt width is $clog2(MAX_BURST+1) (minimum 1) and saturates; it is not used when MAX_BURST=0.
//   - rst during XFER or HDR: on the next edge all outputs take their reset values; a partially sent packet is abandoned, not resumed.
// CONFIGURATION
//   UART_ARB_HDR_EN defined:
//     - After a grant, FSM enters HDR and drives m_axis_tvalid=1, m_axis_tdata=HDR_BASE+grant_id (DATA_WIDTH bits, wraps), all s_axis_tready=0.
//     - When m_axis_tready=1, go to XFER. The header does not count toward MAX_BURST.
//   UART_ARB_HDR_EN undefined:
//     - HDR state and the HDR_BASE logic are absent; IDLE goes directly to XFER.
// TESTING
//   1 Reset: hold rst 3 cycles -> all outputs 0, busy=0; release with no valid -> stays idle.
//   2 Port 2 sends 3 beats 0x41,0x42,0x43 with tlast on 0x43, m_axis_tready=1
//     -> 1 bubble cycle, then 0x41..0x43 on m_axis on consecutive cycles, grant_id=2, busy drops after 0x43.
//   3 Ports 0,1,3 each hold a 2-beat packet valid simultaneously -> served in order 0,1,3, then 0 again if it re-requests; never interleaved.
//   4 Backpressure: m_axis_tready toggled 1,0,0,1 during port 1's packet
//     -> s_axis_tready[1] mirrors it, data held stable, no beats lost or duplicated.
//   5 MAX_BURST=4, port 0 sends 10 beats without tlast while port 1 is pending
//     -> port 0 released after beat 4, port 1 served, then port 0 resumes with beat 5.
//   6 rst pulsed mid-packet at beat 2 of 5 -> next cycle m_axis_tvalid=0, busy=0;
//     with UART_ARB_HDR_EN and port 3 granted, HDR_BASE=0xF0 -> header byte 0xF3 precedes the data.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter that shares one UART transmitter among NUM_PORTS AXI-Stream requesters.
// Latency: one IDLE bubble cycle before each grant starts; the data path is combinational (zero cycles).
// Backpressure: m_axis_tready is routed only to the granted port; every other requester sees tready=0.
// Optional feature: define UART_ARB_HDR_EN to prefix each grant with the header byte HDR_BASE+grant_id.
module uart_tx_arbiter #(
   parameter int                    NUM_PORTS  = 4,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    MAX_BURST  = 0,
   parameter logic [DATA_WIDTH-1:0] HDR_BASE   = 'hF0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
   output logic                            busy
);

   localparam int IDW          = $clog2(NUM_PORTS);
   // beat_cnt needs at least one bit even when the burst limit is disabled
   localparam int BCW          = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
   localparam int BURST_LAST_I = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;

   localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LAST_I);
   localparam logic [BCW-1:0] BEAT_SAT   = {BCW{1'b1}};
   localparam logic [IDW:0]   NP_W       = (IDW + 1)'(NUM_PORTS);
   localparam logic [IDW-1:0] LAST_PORT  = IDW'(NUM_PORTS - 1);

   localparam logic [1:0] IDLE = 2'd0;
`ifdef UART_ARB_HDR_EN
   localparam logic [1:0] HDR  = 2'd1;
`endif
   localparam logic [1:0] XFER = 2'd2;

   logic [1:0]            state;
   logic [IDW-1:0]        rr_ptr;
   logic [BCW-1:0]        beat_cnt;

   logic [DATA_WIDTH-1:0] port_dat [NUM_PORTS];
   logic [IDW-1:0]        winner;
   logic                  winner_vld;
   logic                  beat_acc;
   logic                  grant_rel;

   // Unpack the flat requester data bus into one word per port
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign port_dat[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search: first valid port after rr_ptr, wrapping modulo NUM_PORTS
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] cand;
      winner     = '0;
      winner_vld = 1'b0;
      sum        = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
         if (sum >= NP_W) begin
            sum = sum - NP_W;
         end
         cand = sum[IDW-1:0];
         if (!winner_vld && s_axis_tvalid[cand]) begin
            winner_vld = 1'b1;
            winner     = cand;
         end
      end
   end

   // Output steering: pass the granted port through in XFER, header byte in HDR, quiet otherwise
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      case (state)
         XFER: begin
            m_axis_tdata            = port_dat[grant_id];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            s_axis_tready[grant_id] = m_axis_tready;
         end
`ifdef UART_ARB_HDR_EN
         HDR: begin
            // header wraps within DATA_WIDTH bits
            m_axis_tdata  = HDR_BASE + DATA_WIDTH'(grant_id);
            m_axis_tvalid = 1'b1;
         end
`endif
         default: begin
            m_axis_tdata  = '0;
            m_axis_tvalid = 1'b0;
            s_axis_tready = '0;
         end
      endcase
   end

   // Beat acceptance and release decision for the granted packet
   always_comb begin
      beat_acc  = (state == XFER) && m_axis_tvalid && m_axis_tready;
      grant_rel = 1'b0;
      if (beat_acc) begin
         if (s_axis_tlast[grant_id]) begin
            grant_rel = 1'b1;
         end else if ((MAX_BURST != 0) && (beat_cnt == BURST_LAST)) begin
            grant_rel = 1'b1;
         end
      end
   end

   // Arbitration FSM: grant in IDLE, optional header, then hold until tlast or burst limit
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant_id <= '0;
         busy     <= 1'b0;
         rr_ptr   <= LAST_PORT;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (winner_vld) begin
                  grant_id <= winner;
                  busy     <= 1'b1;
                  beat_cnt <= '0;
`ifdef UART_ARB_HDR_EN
                  state    <= HDR;
`else
                  state    <= XFER;
`endif
               end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
               // the header is not a payload beat, so beat_cnt is untouched
               if (m_axis_tready) begin
                  state <= XFER;
               end
            end
`endif
            XFER: begin
               if (beat_acc && (beat_cnt != BEAT_SAT)) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
               if (grant_rel) begin
                  rr_ptr <= grant_id;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter (4 ports, 8-bit data, MAX_BURST=4).
// Latency: inputs are driven 2 time units after each rising edge, outputs checked 1 unit later.
// Backpressure: m_axis_tready is driven by the bench, including a 1,0,0,1 stall pattern.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_tdata;
   logic [3:0]  s_tvalid;
   logic [3:0]  s_tlast;
   logic [3:0]  s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [1:0]  grant_id;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_PORTS  (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (4),
      .HDR_BASE   (8'hF0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_port(input int p, input logic [7:0] d, input logic v, input logic l);
      s_tdata[p*8 +: 8] = d;
      s_tvalid[p]       = v;
      s_tlast[p]        = l;
   endtask

   // Entered right after the grant edge with port p showing d0; sends d0, d1(last); ends in the bubble
   task automatic xfer2(input int p, input logic [7:0] d0, input logic [7:0] d1, input string tag);
      #1;
      chk({tag, "_gnt"},   grant_id, p);
      chk({tag, "_busy"},  busy, 1);
      chk({tag, "_dat0"},  m_tdata, d0);
      chk({tag, "_rdy"},   s_tready, 32'(1) << p);
      tick();
      set_port(p, d1, 1'b1, 1'b1);
      #1;
      chk({tag, "_dat1"},  m_tdata, d1);
      chk({tag, "_vld1"},  m_tvalid, 1);
      tick();
      set_port(p, 8'h00, 1'b0, 1'b0);
      #1;
      chk({tag, "_rel"},   busy, 0);
      chk({tag, "_bub"},   m_tvalid, 0);
   endtask

   initial begin
      rst      = 1'b1;
      s_tdata  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      m_tready = 1'b0;

      // 1: reset held 3 cycles, then idle with no requests
      repeat (3) tick();
      #1;
      chk("rst_vld",   m_tvalid, 0);
      chk("rst_dat",   m_tdata, 0);
      chk("rst_rdy",   s_tready, 0);
      chk("rst_gnt",   grant_id, 0);
      chk("rst_busy",  busy, 0);
      rst = 1'b0;
      tick();
      tick();
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_vld",  m_tvalid, 0);
      chk("idle_rdy",  s_tready, 0);

      // 2: port 2 sends 41,42,43(last) with a one-cycle bubble first
      m_tready = 1'b1;
      set_port(2, 8'h41, 1'b1, 1'b0);
      #1;
      chk("t2_bubble", m_tvalid, 0);
      chk("t2_bub_rdy", s_tready, 0);
      tick();
      #1;
      chk("t2_gnt",    grant_id, 2);
      chk("t2_busy",   busy, 1);
      chk("t2_dat0",   m_tdata, 8'h41);
      chk("t2_rdy",    s_tready, 4'b0100);
      tick();
      set_port(2, 8'h42, 1'b1, 1'b0);
      #1;
      chk("t2_dat1",   m_tdata, 8'h42);
      tick();
      set_port(2, 8'h43, 1'b1, 1'b1);
      #1;
      chk("t2_dat2",   m_tdata, 8'h43);
      tick();
      set_port(2, 8'h00, 1'b0, 1'b0);
      #1;
      chk("t2_rel",    busy, 0);
      chk("t2_relvld", m_tvalid, 0);
      chk("t2_gnthold", grant_id, 2);

      // 3: reset pointer, then ports 0,1,3 contend -> 0,1,3, then 0 again
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_port(0, 8'hA0, 1'b1, 1'b0);
      set_port(1, 8'hB0, 1'b1, 1'b0);
      set_port(3, 8'hD0, 1'b1, 1'b0);
      #1;
      chk("t3_bubble", m_tvalid, 0);
      tick();
      xfer2(0, 8'hA0, 8'hA1, "t3_p0a");
      set_port(0, 8'hA2, 1'b1, 1'b0);
      #1;
      chk("t3_bub_rdy", s_tready, 0);
      tick();
      xfer2(1, 8'hB0, 8'hB1, "t3_p1");
      tick();
      xfer2(3, 8'hD0, 8'hD1, "t3_p3");
      tick();
      xfer2(0, 8'hA2, 8'hA3, "t3_p0b");

      // 4: backpressure 1,0,0,1 on port 1's packet C0,C1,C2(last)
      set_port(1, 8'hC0, 1'b1, 1'b0);
      tick();
      #1;
      chk("t4_gnt",    grant_id, 1);
      chk("t4_dat0",   m_tdata, 8'hC0);
      chk("t4_rdy0",   s_tready, 4'b0010);
      tick();
      set_port(1, 8'hC1, 1'b1, 1'b0);
      m_tready = 1'b0;
      #1;
      chk("t4_rdy1",   s_tready, 4'b0000);
      chk("t4_dat1",   m_tdata, 8'hC1);
      tick();
      #1;
      chk("t4_rdy2",   s_tready, 4'b0000);
      chk("t4_dat1h",  m_tdata, 8'hC1);
      chk("t4_busy",   busy, 1);
      m_tready = 1'b1;
      #1;
      chk("t4_rdy3",   s_tready, 4'b0010);
      chk("t4_dat1r",  m_tdata, 8'hC1);
      tick();
      set_port(1, 8'hC2, 1'b1, 1'b1);
      #1;
      chk("t4_dat2",   m_tdata, 8'hC2);
      tick();
      set_port(1, 8'h00, 1'b0, 1'b0);
      #1;
      chk("t4_rel",    busy, 0);

      // 5: burst limit 4 on port 0 with port 1 pending
      set_port(0, 8'h50, 1'b1, 1'b0);
      set_port(1, 8'h60, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t5_gnt0",  grant_id, 0);
         chk("t5_dat",   m_tdata, 8'h50 + 8'(i));
         tick();
         set_port(0, 8'h51 + 8'(i), 1'b1, 1'b0);
      end
      #1;
      chk("t5_forcerel", busy, 0);
      chk("t5_bubble", m_tvalid, 0);
      tick();
      xfer2(1, 8'h60, 8'h61, "t5_p1");
      tick();
      #1;
      chk("t5_resume_gnt", grant_id, 0);
      chk("t5_resume_dat", m_tdata, 8'h54);
      for (int i = 4; i < 8; i++) begin
         #1;
         chk("t5_dat2",  m_tdata, 8'h50 + 8'(i));
         tick();
         set_port(0, 8'h51 + 8'(i), 1'b1, 1'b0);
      end
      #1;
      chk("t5_rel2",   busy, 0);
      tick();
      for (int i = 8; i < 10; i++) begin
         #1;
         chk("t5_dat3",  m_tdata, 8'h50 + 8'(i));
         tick();
         set_port(0, 8'h51 + 8'(i), 1'b1, 1'b0);
      end
      // port 0 goes quiet mid-packet: grant is held, port 1 must wait
      set_port(0, 8'h00, 1'b0, 1'b0);
      set_port(1, 8'h62, 1'b1, 1'b1);
      #1;
      chk("t5_hold_busy", busy, 1);
      chk("t5_hold_vld", m_tvalid, 0);
      chk("t5_hold_rdy", s_tready, 4'b0001);
      tick();
      #1;
      chk("t5_hold_gnt", grant_id, 0);
      chk("t5_hold_busy2", busy, 1);
      set_port(0, 8'h5A, 1'b1, 1'b1);
      #1;
      chk("t5_last_dat", m_tdata, 8'h5A);
      tick();
      set_port(0, 8'h00, 1'b0, 1'b0);
      #1;
      chk("t5_last_rel", busy, 0);
      tick();
      #1;
      chk("t5_p1_gnt", grant_id, 1);
      chk("t5_p1_dat", m_tdata, 8'h62);
      tick();
      set_port(1, 8'h00, 1'b0, 1'b0);
      #1;
      chk("t5_p1_rel", busy, 0);

      // 6: reset mid-packet at beat 2 of 5 from port 2
      set_port(2, 8'h70, 1'b1, 1'b0);
      tick();
      #1;
      chk("t6_gnt",    grant_id, 2);
      chk("t6_dat0",   m_tdata, 8'h70);
      tick();
      set_port(2, 8'h71, 1'b1, 1'b0);
      #1;
      chk("t6_dat1",   m_tdata, 8'h71);
      rst = 1'b1;
      tick();
      #1;
      chk("t6_rst_vld",  m_tvalid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_gnt",  grant_id, 0);
      chk("t6_rst_rdy",  s_tready, 0);
      chk("t6_rst_dat",  m_tdata, 0);
      rst = 1'b0;
      set_port(2, 8'h00, 1'b0, 1'b0);
      set_port(3, 8'h80, 1'b1, 1'b1);
      set_port(0, 8'h90, 1'b1, 1'b1);
      tick();
      #1;
      chk("t6_ptr_gnt",  grant_id, 0);
      chk("t6_ptr_dat",  m_tdata, 8'h90);
      set_port(0, 8'h00, 1'b0, 1'b0);
      set_port(3, 8'h00, 1'b0, 1'b0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
